// File: rtl/kan_axis_pkg.sv
// Lane-slicing helpers and the lane enable mask type, shared by the KAN
// stream splitter and combiner.
package kan_axis_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_CHANNELS   = 16;

   typedef logic [DEF_CHANNELS-1:0] lane_mask_t;

   // Bit offset of lane c inside a packed multi-lane word.
   function automatic int lane_offset(input int data_width, input int c);
      return data_width * c;
   endfunction

endpackage

// File: rtl/axis_combiner_slot.sv
// One-entry lane slot: holds one beat (data + last) and a full bit.
// A write in the same cycle as a clear wins, so the slot stays full.
module axis_combiner_slot
   import kan_axis_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_wr_last,
   input  logic                  i_clr,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   output logic                  o_full
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_last;
   logic                  r_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_last <= 1'b0;
         r_full <= 1'b0;
      end else if (i_wr) begin
         r_data <= i_wr_data;
         r_last <= i_wr_last;
         r_full <= 1'b1;
      end else if (i_clr) begin
         r_full <= 1'b0;
      end
   end

   assign o_data = r_data;
   assign o_last = r_last;
   assign o_full = r_full;

endmodule

// File: rtl/axis_combiner.sv
// Packs CHANNELS narrow AXI-Stream lanes into one wide word once every enabled
// lane holds a beat. Optional sticky tlast check: AXIS_COMBINER_TLAST_CHECK_EN.
module axis_combiner
   import kan_axis_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CHANNELS   = DEF_CHANNELS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CHANNELS-1:0]            chan_en,
   input  logic [DATA_WIDTH*CHANNELS-1:0] s_axis_0_tdata,
   input  logic [CHANNELS-1:0]            s_axis_0_tvalid,
   output logic [CHANNELS-1:0]            s_axis_0_tready,
   input  logic [CHANNELS-1:0]            s_axis_0_tlast,
   output logic [DATA_WIDTH*CHANNELS-1:0] m_axis_0_tdata,
   output logic [CHANNELS-1:0]            m_axis_0_tkeep,
   output logic                           m_axis_0_tvalid,
   input  logic                           m_axis_0_tready,
   output logic                           m_axis_0_tlast
`ifdef AXIS_COMBINER_TLAST_CHECK_EN
   ,
   output logic                           err_tlast
`endif
);

   logic [CHANNELS-1:0]            w_full;
   logic [CHANNELS-1:0]            w_slot_last;
   logic [CHANNELS-1:0]            w_accept;
   logic [CHANNELS-1:0]            w_clr;
   logic [DATA_WIDTH*CHANNELS-1:0] w_slot_data;
   logic [DATA_WIDTH*CHANNELS-1:0] w_gather;
   logic                           w_ready_all;
   logic                           w_any_en;
   logic                           w_last_all;
   logic                           w_load;

   logic [DATA_WIDTH*CHANNELS-1:0] r_tdata;
   logic [CHANNELS-1:0]            r_tkeep;
   logic                           r_tvalid;
   logic                           r_tlast;

   // Disabled lanes count as satisfied, so the word waits only on enabled ones.
   assign w_ready_all = &(w_full | ~chan_en);
   assign w_any_en    = |chan_en;
   assign w_last_all  = &(w_slot_last | ~chan_en);
   assign w_load      = w_ready_all && w_any_en && (!r_tvalid || m_axis_0_tready);
   assign w_accept    = s_axis_0_tvalid & s_axis_0_tready;
   assign w_clr       = chan_en & {CHANNELS{w_load}};

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      localparam int LO = lane_offset(DATA_WIDTH, gi);

      axis_combiner_slot #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .i_wr      (w_accept[gi]),
         .i_wr_data (s_axis_0_tdata[LO +: DATA_WIDTH]),
         .i_wr_last (s_axis_0_tlast[gi]),
         .i_clr     (w_clr[gi]),
         .o_data    (w_slot_data[LO +: DATA_WIDTH]),
         .o_last    (w_slot_last[gi]),
         .o_full    (w_full[gi])
      );

      assign w_gather[LO +: DATA_WIDTH] = chan_en[gi] ? w_slot_data[LO +: DATA_WIDTH] : '0;
      assign s_axis_0_tready[gi] = !rst && chan_en[gi] && (!w_full[gi] || w_load);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else if (w_load) begin
         r_tdata  <= w_gather;
         r_tkeep  <= chan_en;
         r_tvalid <= 1'b1;
         r_tlast  <= w_last_all;
      end else if (r_tvalid && m_axis_0_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign m_axis_0_tdata  = r_tdata;
   assign m_axis_0_tkeep  = r_tkeep;
   assign m_axis_0_tvalid = r_tvalid;
   assign m_axis_0_tlast  = r_tlast;

`ifdef AXIS_COMBINER_TLAST_CHECK_EN
   logic r_err_tlast;
   logic w_last_any;

   // Mixed last bits: some enabled lane ends a packet while another does not.
   assign w_last_any = |(w_slot_last & chan_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_tlast <= 1'b0;
      end else if (w_load && w_last_any && !w_last_all) begin
         r_err_tlast <= 1'b1;
      end
   end

   assign err_tlast = r_err_tlast;
`endif

endmodule

// File: tb/tb_axis_combiner.sv
// Directed bench for axis_combiner with CHANNELS=4, DATA_WIDTH=16.
// Build with AXIS_COMBINER_TLAST_CHECK_EN to also check err_tlast.
module tb_axis_combiner;

   localparam int DW = 16;
   localparam int CH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [CH-1:0]   chan_en;
   logic [DW*CH-1:0] s_tdata;
   logic [CH-1:0]   s_tvalid;
   logic [CH-1:0]   s_tready;
   logic [CH-1:0]   s_tlast;
   logic [DW*CH-1:0] m_tdata;
   logic [CH-1:0]   m_tkeep;
   logic            m_tvalid;
   logic            m_tready;
   logic            m_tlast;
`ifdef AXIS_COMBINER_TLAST_CHECK_EN
   logic            err_tlast;
`endif

   int n_checks = 0;
   int n_errors = 0;

   axis_combiner #(
      .DATA_WIDTH (DW),
      .CHANNELS   (CH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .chan_en         (chan_en),
      .s_axis_0_tdata  (s_tdata),
      .s_axis_0_tvalid (s_tvalid),
      .s_axis_0_tready (s_tready),
      .s_axis_0_tlast  (s_tlast),
      .m_axis_0_tdata  (m_tdata),
      .m_axis_0_tkeep  (m_tkeep),
      .m_axis_0_tvalid (m_tvalid),
      .m_axis_0_tready (m_tready),
      .m_axis_0_tlast  (m_tlast)
`ifdef AXIS_COMBINER_TLAST_CHECK_EN
      ,
      .err_tlast       (err_tlast)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   // Beat k, lane c: beat 0 is the fixed test word, others are {k, c}.
   function automatic logic [15:0] lane_val(input int k, input int c);
      logic [15:0] v;
      if (k == 0) begin
         case (c)
            0:       v = 16'hBEBE;
            1:       v = 16'hCAFE;
            2:       v = 16'hBEAF;
            default: v = 16'hDEAD;
         endcase
      end else begin
         v = 16'(k * 256 + c);
      end
      return v;
   endfunction

   function automatic logic [63:0] beat_word(input int k);
      logic [63:0] w;
      for (int c = 0; c < CH; c++) w[16*c +: 16] = lane_val(k, c);
      return w;
   endfunction

   initial begin
      rst      = 1'b1;
      chan_en  = 4'hF;
      s_tdata  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      m_tready = 1'b1;

      // Reset state
      step();
      step();
      check("rst_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_tdata",  m_tdata, 64'd0);
      check("rst_tkeep",  64'(m_tkeep), 64'd0);
      check("rst_tlast",  64'(m_tlast), 64'd0);
      check("rst_tready", 64'(s_tready), 64'd0);
`ifdef AXIS_COMBINER_TLAST_CHECK_EN
      check("rst_err", 64'(err_tlast), 64'd0);
`endif
      rst = 1'b0;
      #1;
      check("idle_tready", 64'(s_tready), 64'hF);

      // Full-rate streaming, tlast on beat 4
      for (int i = 0; i < 8; i++) begin
         s_tdata  = beat_word(i);
         s_tvalid = 4'hF;
         s_tlast  = (i == 4) ? 4'hF : 4'h0;
         step();
         if (i == 0) begin
            check("lat_tvalid0", 64'(m_tvalid), 64'd0);
         end else begin
            check("str_tvalid", 64'(m_tvalid), 64'd1);
            check("str_tdata",  m_tdata, beat_word(i - 1));
            check("str_tlast",  64'(m_tlast), (i - 1 == 4) ? 64'd1 : 64'd0);
         end
         if (i == 1) check("str_word0", m_tdata, 64'hDEAD_BEAF_CAFE_BEBE);
         if (i == 1) check("str_tkeep", 64'(m_tkeep), 64'hF);
      end
      s_tvalid = 4'h0;
      s_tlast  = 4'h0;
      step();
      check("str_last_word", m_tdata, beat_word(7));
      step();
      check("str_drained", 64'(m_tvalid), 64'd0);

      // Lane 2 delayed by 3 cycles
      s_tdata  = beat_word(10);
      s_tvalid = 4'b1011;
      step();
      for (int i = 0; i < 3; i++) begin
         check("dly_tready", 64'(s_tready), 64'b0100);
         check("dly_tvalid", 64'(m_tvalid), 64'd0);
         step();
      end
      s_tvalid = 4'hF;
      step();
      s_tvalid = 4'h0;
      check("dly_wait", 64'(m_tvalid), 64'd0);
      step();
      check("dly_tvalid1", 64'(m_tvalid), 64'd1);
      check("dly_tdata",   m_tdata, 64'h0A03_0A02_0A01_0A00);
      step();
      check("dly_single", 64'(m_tvalid), 64'd0);

      // Output back-pressure for 5 cycles
      m_tready = 1'b0;
      s_tdata  = beat_word(21);
      s_tvalid = 4'hF;
      step();
      s_tdata = beat_word(22);
      step();
      check("bp_tvalid", 64'(m_tvalid), 64'd1);
      check("bp_first",  m_tdata, 64'h1503_1502_1501_1500);
      s_tdata = beat_word(23);
      for (int i = 0; i < 5; i++) begin
         check("bp_tready", 64'(s_tready), 64'd0);
         check("bp_hold",   m_tdata, 64'h1503_1502_1501_1500);
         step();
      end
      m_tready = 1'b1;
      #1;
      check("bp_release", 64'(s_tready), 64'hF);
      step();
      s_tvalid = 4'h0;
      check("bp_word22", m_tdata, 64'h1603_1602_1601_1600);
      step();
      check("bp_word23", m_tdata, 64'h1703_1702_1701_1700);
      step();
      check("bp_drained", 64'(m_tvalid), 64'd0);

      // Partial lane mask 0x5, then all lanes disabled
      chan_en  = 4'h5;
      s_tdata  = beat_word(30);
      s_tvalid = 4'hF;
      #1;
      check("msk_tready", 64'(s_tready), 64'h5);
      step();
      s_tvalid = 4'h0;
      step();
      check("msk_tdata", m_tdata, 64'h0000_1E02_0000_1E00);
      check("msk_tkeep", 64'(m_tkeep), 64'h5);
      step();
      chan_en  = 4'h0;
      s_tvalid = 4'hF;
      #1;
      check("off_tready", 64'(s_tready), 64'd0);
      step();
      step();
      check("off_tvalid", 64'(m_tvalid), 64'd0);
      s_tvalid = 4'h0;

      // Mismatched tlast across enabled lanes
      chan_en  = 4'h3;
      s_tdata  = beat_word(40);
      s_tvalid = 4'hF;
      s_tlast  = 4'b0001;
      step();
      s_tvalid = 4'h0;
      s_tlast  = 4'h0;
      step();
      check("mis_tdata", m_tdata, 64'h0000_0000_2801_2800);
      check("mis_tkeep", 64'(m_tkeep), 64'h3);
      check("mis_tlast", 64'(m_tlast), 64'd0);
`ifdef AXIS_COMBINER_TLAST_CHECK_EN
      check("mis_err", 64'(err_tlast), 64'd1);
`endif
      step();

      // Reset with two slots full and an output pending
      chan_en  = 4'hF;
      m_tready = 1'b0;
      s_tdata  = beat_word(50);
      s_tvalid = 4'hF;
      step();
      s_tdata  = beat_word(51);
      s_tvalid = 4'b0011;
      step();
      s_tvalid = 4'h0;
      check("pre_rst_tvalid", 64'(m_tvalid), 64'd1);
      rst = 1'b1;
      #1;
      check("in_rst_tready", 64'(s_tready), 64'd0);
      step();
      check("rst2_tvalid", 64'(m_tvalid), 64'd0);
      check("rst2_tready", 64'(s_tready), 64'd0);
      check("rst2_tdata",  m_tdata, 64'd0);
`ifdef AXIS_COMBINER_TLAST_CHECK_EN
      check("rst2_err", 64'(err_tlast), 64'd0);
`endif
      rst      = 1'b0;
      m_tready = 1'b1;
      s_tdata  = beat_word(52);
      s_tvalid = 4'hF;
      #1;
      check("post_tready", 64'(s_tready), 64'hF);
      step();
      s_tvalid = 4'h0;
      step();
      check("post_tvalid", 64'(m_tvalid), 64'd1);
      check("post_tdata",  m_tdata, 64'h3403_3402_3401_3400);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axis_combiner.md
# axis_combiner

Gathers CHANNELS independent narrow AXI-Stream lanes into a single wide AXI-Stream word. It is the downstream counterpart of the per-lane splitter and FIFO stage: each lane's beats are captured in a one-entry slot, and a wide word is emitted once every enabled lane holds a beat. It sits at the output of the per-channel KAN compute lanes and re-packs their results for the wide datapath or DMA.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one lane
- CHANNELS, 16, number of lanes

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset; synchronous, active-high
- chan_en  in  CHANNELS  lane enable mask, sampled every cycle
- s_axis_0_tdata  in  DATA_WIDTH*CHANNELS  lane c occupies bits [DATA_WIDTH*(c+1)-1 : DATA_WIDTH*c]
- s_axis_0_tvalid  in  CHANNELS  per-lane valid
- s_axis_0_tready  out  CHANNELS  per-lane ready
- s_axis_0_tlast  in  CHANNELS  per-lane last
- m_axis_0_tdata  out  DATA_WIDTH*CHANNELS  packed output word
- m_axis_0_tkeep  out  CHANNELS  lanes that contributed to this word
- m_axis_0_tvalid  out  1  output valid
- m_axis_0_tready  in  1  output ready
- m_axis_0_tlast  out  1  output last
- err_tlast  out  1  sticky tlast-mismatch flag; present only with AXIS_COMBINER_TLAST_CHECK_EN

## Operation
- Each lane c has a slot holding data, last and a full bit. A lane beat is accepted when s_axis_0_tvalid[c] && s_axis_0_tready[c]. On acceptance the slot is written and its full bit is set.
- ready_all = AND over c of (full[c] || !chan_en[c]). The word is ready to emit when ready_all is true and chan_en != 0.
- load = ready_all && (chan_en != 0) && (!m_axis_0_tvalid || m_axis_0_tready).
- On load, the output register captures:
  - tdata: slot data for each enabled lane; disabled lanes are zero.
  - tkeep: chan_en.
  - tlast: AND of slot last over enabled lanes.
- On load, all enabled slots clear. A lane beat accepted in the same cycle refills its slot, so the slot stays full.
- s_axis_0_tready[c] = !rst && chan_en[c] && (!full[c] || load).
- Disabled lanes are not drained. Their tready is 0 and their slot contents are held.
- Output handshake: m_axis_0_tvalid is set on load. It clears on m_axis_0_tvalid && m_axis_0_tready when no load happens in that cycle. While stalled, tdata, tkeep and tlast are held stable.
- chan_en may change at any time. Only the value present in the load cycle is used.
- chan_en == 0: nothing is emitted, all tready are 0, and state is held.

## Timing
- Latency: a lane beat accepted at edge N makes its slot full after N. If it completes the set, m_axis_0_tvalid is high after edge N+1 (2 cycles).
- Throughput: one wide word per cycle when all lanes stream and the output is never stalled.
- Back-pressure: while m_axis_0_tready is low and m_axis_0_tvalid is high, full slots stay full, their tready is 0, and empty slots still accept one beat.
- Reset values:
  - full = 0 and output register cleared, so m_axis_0_tvalid = 0, tdata = 0, tkeep = 0, tlast = 0.
  - s_axis_0_tready = 0 during rst.
  - err_tlast = 0.
- Reset mid-operation discards slot contents and any pending output word, with no partial emission.

## Configuration
- AXIS_COMBINER_TLAST_CHECK_EN defined:
  - On load, if the enabled lanes' last bits are not all equal, err_tlast sets and stays set until rst.
  - The emitted tlast is still the AND of the enabled lanes' last bits.
- Undefined: no err_tlast port and no check logic. tlast is the AND of the enabled lanes' last bits.

## Structure
- Shared package kan_axis_pkg holds the lane-slice helper constants (lane offset = DATA_WIDTH*c) and the lane enable mask type, shared with the splitter.
- Sub-module axis_combiner_slot: one-entry register with full bit, write port and clear-on-load. Instantiate one per lane in a generate loop; the top holds the gather logic and output register.

## Test plan
CHANNELS=4, DATA_WIDTH=16.
- All lanes valid together with data 0xBEBE/0xCAFE/0xBEAF/0xDEAD, chan_en=0xF, m_ready=1 -> m_tdata=0xDEADBEAFCAFEBEBE, tkeep=0xF, tvalid two cycles after the input edge, then one word per cycle for 8 beats.
- Lane 2 delayed 3 cycles -> no output until lane 2's beat; lanes 0, 1 and 3 show tready=0 while full; a single word is emitted after lane 2 arrives.
- m_ready=0 for 5 cycles with all lanes streaming -> output held stable, each lane accepts exactly one extra beat, and no beat is lost or duplicated after release.
- chan_en=0x5 -> tkeep=0x5, lanes 1 and 3 zero in tdata, tready[1]=tready[3]=0; chan_en=0 -> no output.
- tlast set on all lanes on beat 4 -> m_tlast=1 only on word 4. Lane 0 last=1 and lane 1 last=0 on the same word -> m_tlast=0, and err_tlast=1 when the macro is defined.
- rst asserted with two slots full and an output pending -> the next edge shows tvalid=0 and all tready=0; after release, the first word contains only beats sent after reset.
